add32_mp_seq: RTL and testbench

- Sequencing stage wrapped around the team's 32-bit adders (csadd32/rcadd32).
- Accepts a stream of operand word pairs over a valid/ready handshake and drives them onto an external adder's a/b/cin inputs.
- Waits a programmable settle time so the gate-delayed adder outputs are stable, then captures s/cout and returns them as a result stream.
- Chains cout into the next word's cin, giving multi-precision (N×32-bit) addition.

---
 rtl/add32_mp_seq.sv | 135 +++++++++++++
 tb/tb_add32_mp_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/add32_mp_seq.sv
// add32_mp_seq: sequences operand word pairs onto an external 32-bit adder,
// waits a fixed settle time, captures sum/carry and chains carry across words
// for multi-precision addition.
module add32_mp_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned IDXW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_last,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_last,
  output logic [IDXW-1:0]  out_idx
);

  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t            state, state_nx;
  logic              first, first_nx;
  logic              carry, carry_nx;
  logic [CNTW-1:0]   cnt, cnt_nx;
  logic              last_r, last_r_nx;
  logic [WIDTH-1:0]  add_a_nx, add_b_nx;
  logic              add_cin_nx;
  logic              out_valid_nx;
  logic [WIDTH-1:0]  out_sum_nx;
  logic              out_cout_nx;
  logic              out_last_nx;
  logic [IDXW-1:0]   out_idx_nx;

  // Upstream may only hand over a word while no word is in flight.
  assign in_ready = (state == IDLE);

  // State and datapath registers; reset discards any partial operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      first     <= 1'b1;
      carry     <= 1'b0;
      cnt       <= '0;
      last_r    <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
    end else begin
      state     <= state_nx;
      first     <= first_nx;
      carry     <= carry_nx;
      cnt       <= cnt_nx;
      last_r    <= last_r_nx;
      add_a     <= add_a_nx;
      add_b     <= add_b_nx;
      add_cin   <= add_cin_nx;
      out_valid <= out_valid_nx;
      out_sum   <= out_sum_nx;
      out_cout  <= out_cout_nx;
      out_last  <= out_last_nx;
      out_idx   <= out_idx_nx;
    end
  end

  // Next-state and next-register values; everything holds unless updated.
  always_comb begin
    state_nx     = state;
    first_nx     = first;
    carry_nx     = carry;
    cnt_nx       = cnt;
    last_r_nx    = last_r;
    add_a_nx     = add_a;
    add_b_nx     = add_b;
    add_cin_nx   = add_cin;
    out_valid_nx = out_valid;
    out_sum_nx   = out_sum;
    out_cout_nx  = out_cout;
    out_last_nx  = out_last;
    out_idx_nx   = out_idx;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          add_a_nx   = in_a;
          add_b_nx   = in_b;
          add_cin_nx = first ? in_cin : carry;
          last_r_nx  = in_last;
          out_idx_nx = first ? '0 : out_idx + IDXW'(1);
          cnt_nx     = CNTW'(SETTLE - 1);
          state_nx   = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNTW'(1);
        end else begin
          out_sum_nx   = add_s;
          out_cout_nx  = add_cout;
          carry_nx     = add_cout;
          out_last_nx  = last_r;
          out_valid_nx = 1'b1;
          state_nx     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          first_nx     = out_last;
          if (out_last) carry_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_add32_mp_seq.sv
// tb_add32_mp_seq: directed vectors against add32_mp_seq with a behavioural
// adder standing in for the external csadd32/rcadd32.
`timescale 1ns/1ps
module tb_add32_mp_seq;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned IDXW   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             in_cin, in_last;
  logic [WIDTH-1:0] add_a, add_b, add_s;
  logic             add_cin, add_cout;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout, out_last;
  logic [IDXW-1:0]  out_idx;

  int n_checks = 0;
  int n_errors = 0;

  add32_mp_seq #(.WIDTH(WIDTH), .SETTLE(SETTLE), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_last(out_last),
    .out_idx(out_idx)
  );

  // Stand-in external adder.
  assign {add_cout, add_s} = 33'(add_a) + 33'(add_b) + 33'(add_cin);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Push one word, check adder drive, latency, captured result, then release.
  task automatic do_word(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic last, input logic [31:0] es, input logic ec,
                         input logic [7:0] ei, input logic eac, input int hold);
    int lat;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    in_a = a; in_b = b; in_cin = cin; in_last = last; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("add_cin", 64'(add_cin), 64'(eac));
    check("add_a", 64'(add_a), 64'(a));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(SETTLE));
    check("out_sum", 64'(out_sum), 64'(es));
    check("out_cout", 64'(out_cout), 64'(ec));
    check("out_idx", 64'(out_idx), 64'(ei));
    check("out_last", 64'(out_last), 64'(last));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_a = 32'hDEAD_0000 + 32'(i); in_b = 32'h1234_5678; in_cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_sum", 64'(out_sum), 64'(es));
      check("hold_cout", 64'(out_cout), 64'(ec));
      check("hold_idx", 64'(out_idx), 64'(ei));
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_add_a", 64'(add_a), 64'(a));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", 64'(out_valid), 64'(0));
    check("release_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_last = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_add", 64'({add_a, add_b}) | 64'(add_cin), 64'(0));
    check("rst_out", 64'(out_sum) | 64'({out_cout, out_last, out_idx}), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    // Single word: 1 + FFFFFFFF
    do_word(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b1, 8'd0, 1'b0, 0);

    // Two-word chain, then a fresh op with no carry leak
    do_word(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1, 8'd0, 1'b0, 0);
    do_word(32'h0, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0, 8'd1, 1'b1, 0);
    do_word(32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 8'd0, 1'b0, 0);

    // First-word carry-in honoured
    do_word(32'h0, 32'h0, 1'b1, 1'b1, 32'h1, 1'b0, 8'd0, 1'b1, 0);
    // Non-first word ignores in_cin
    do_word(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 1'b0, 0);
    do_word(32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 8'd1, 1'b0, 0);

    // Backpressure: 5 cycles of out_ready=0 with in_valid pulses
    do_word(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_6789, 1'b0, 8'd0, 1'b0, 5);

    // Reset mid-WAIT with carry=1 pending
    do_word(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1, 8'd0, 1'b0, 0);
    @(negedge clk);
    in_a = 32'h7; in_b = 32'h9; in_cin = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_add_cin", 64'(add_cin), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_add", 64'({add_a, add_b}) | 64'(add_cin), 64'(0));
    check("arst_out", 64'(out_sum) | 64'({out_valid, out_cout, out_last, out_idx}), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk); rst_n = 1'b1;
    do_word(32'h5, 32'h3, 1'b0, 1'b1, 32'h8, 1'b0, 8'd0, 1'b0, 0);

    // Index wrap: 257 non-last words then a last word
    for (int i = 0; i < 257; i++)
      do_word(32'(i), 32'h1, 1'b0, 1'b0, 32'(i + 1), 1'b0, 8'(i), 1'b0, 0);
    do_word(32'h10, 32'h20, 1'b0, 1'b1, 32'h30, 1'b0, 8'd1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
